mlp_layer_sequencer: RTL and testbench

//  Sequencer for the single-MAC dense-layer datapath (784 pixels x 10 neurons) of the MNIST classifier.

---
 rtl/mlp_layer_sequencer_pkg.sv | 29 ++
 rtl/mlp_layer_sequencer_if.sv | 35 +++
 rtl/mlp_argmax_tracker.sv | 47 ++++
 rtl/mlp_layer_sequencer.sv | 142 ++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mlp_layer_sequencer_pkg.sv
// Shared constants and state encoding for the MNIST dense-layer sequencer.
// Defaults describe the 784-pixel x 10-neuron layer with a single-cycle ROM.
package mlp_layer_sequencer_pkg;

    localparam int DEF_N_PIX   = 784;
    localparam int DEF_N_OUT   = 10;
    localparam int DEF_MEM_LAT = 1;
    localparam int DEF_ACC_W   = 34;

    localparam int PIX_AW = 10;
    localparam int WGT_AW = 13;
    localparam int OUT_AW = 4;

    localparam logic signed [DEF_ACC_W-1:0] ACC_MIN =
        {1'b1, {(DEF_ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_CMP,
        S_DONE
    } state_e;

    function automatic int drain_cnt_w(input int mem_lat);
        return $clog2(mem_lat + 1) + 1;
    endfunction

endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// Control handshake plus ROM/MAC datapath bundle of the layer sequencer.
// master = sequencer side, slave = board top and MAC datapath side.
interface mlp_layer_sequencer_if
    import mlp_layer_sequencer_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) ();

    logic                    start;
    logic                    busy;
    logic                    done;
    logic [OUT_AW-1:0]       predicted_digit;
    logic                    rd_en;
    logic [PIX_AW-1:0]       pix_addr;
    logic [WGT_AW-1:0]       wgt_addr;
    logic [OUT_AW-1:0]       bias_addr;
    logic                    mac_clear;
    logic                    mac_en;
    logic signed [ACC_W-1:0] acc_in;

    modport master (
        input  start, acc_in,
        output busy, done, predicted_digit, rd_en,
        output pix_addr, wgt_addr, bias_addr,
        output mac_clear, mac_en
    );

    modport slave (
        output start, acc_in,
        input  busy, done, predicted_digit, rd_en,
        input  pix_addr, wgt_addr, bias_addr,
        input  mac_clear, mac_en
    );

endinterface

// File: rtl/mlp_argmax_tracker.sv
// Running argmax over neuron scores; strict greater-than so ties keep the
// lower index. The digit survives clr so it only changes on a real update.
module mlp_argmax_tracker
    import mlp_layer_sequencer_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int IDX_W = OUT_AW
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [ACC_W-1:0] value_i,
    input  logic [IDX_W-1:0]        idx_i,
    output logic [IDX_W-1:0]        digit_o
);

    localparam logic signed [ACC_W-1:0] MIN =
        {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]        dig_q, dig_d;

    always_comb begin
        max_d = max_q;
        dig_d = dig_q;
        if (clr_i) begin
            max_d = MIN;
        end else if (en_i && (value_i > max_q)) begin
            max_d = value_i;
            dig_d = idx_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_q <= MIN;
            dig_q <= '0;
        end else begin
            max_q <= max_d;
            dig_q <= dig_d;
        end
    end

    assign digit_o = dig_q;

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Walks neurons x pixels for the single-MAC dense layer, drives ROM
// addresses and delayed accumulator strobes, and tracks the argmax.
module mlp_layer_sequencer
    import mlp_layer_sequencer_pkg::*;
#(
    parameter int N_PIX   = DEF_N_PIX,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    mlp_layer_sequencer_if.master bus
);

    localparam int CW = drain_cnt_w(MEM_LAT);

    state_e              state_q, state_d;
    logic                start_q;
    logic [OUT_AW-1:0]   n_q, n_d;
    logic [PIX_AW-1:0]   p_q, p_d;
    logic [WGT_AW-1:0]   wgt_q, wgt_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [MEM_LAT-1:0]  vld_q, vld_d;
    logic [MEM_LAT-1:0]  fst_q, fst_d;
    logic                trk_clr;
    logic                trk_en;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        p_d     = p_q;
        wgt_d   = wgt_q;
        cnt_d   = cnt_q;
        trk_clr = 1'b0;
        trk_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    state_d = S_ISSUE;
                    n_d     = '0;
                    p_d     = '0;
                    wgt_d   = '0;
                    trk_clr = 1'b1;
                end
            end
            S_ISSUE: begin
                if (p_q == PIX_AW'(N_PIX - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    p_d   = p_q + PIX_AW'(1);
                    wgt_d = wgt_q + WGT_AW'(N_OUT);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(MEM_LAT)) begin
                    state_d = S_CMP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CMP: begin
                trk_en = 1'b1;
                if (n_q == OUT_AW'(N_OUT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    n_d     = n_q + OUT_AW'(1);
                    p_d     = '0;
                    wgt_d   = WGT_AW'(n_q) + WGT_AW'(1);
                end
            end
            S_DONE: begin
                if (!start_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage 0 is the issue beat; the last stage lines up with ROM data.
    always_comb begin
        vld_d    = vld_q;
        fst_d    = fst_q;
        vld_d[0] = (state_q == S_ISSUE);
        fst_d[0] = (state_q == S_ISSUE) && (p_q == '0);
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            fst_d[i] = fst_q[i-1];
        end
    end

    // start is a board switch: register it once before the FSM sees it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            n_q     <= '0;
            p_q     <= '0;
            wgt_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            fst_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            n_q     <= n_d;
            p_q     <= p_d;
            wgt_q   <= wgt_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            fst_q   <= fst_d;
        end
    end

    mlp_argmax_tracker #(
        .ACC_W (ACC_W),
        .IDX_W (OUT_AW)
    ) u_argmax (
        .clk_i   (CLOCK_50),
        .rst_ni  (reset_n),
        .clr_i   (trk_clr),
        .en_i    (trk_en),
        .value_i (bus.acc_in),
        .idx_i   (n_q),
        .digit_o (bus.predicted_digit)
    );

    assign bus.busy      = (state_q == S_ISSUE) ||
                           (state_q == S_DRAIN) ||
                           (state_q == S_CMP);
    assign bus.done      = (state_q == S_DONE);
    assign bus.rd_en     = (state_q == S_ISSUE);
    assign bus.pix_addr  = p_q;
    assign bus.wgt_addr  = wgt_q;
    assign bus.bias_addr = n_q;
    assign bus.mac_clear = vld_q[MEM_LAT-1] & fst_q[MEM_LAT-1];
    assign bus.mac_en    = vld_q[MEM_LAT-1] & ~fst_q[MEM_LAT-1];

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: two builds (MEM_LAT 1 and 3),
// a score table driven from bias_addr and an address/strobe monitor.
module tb_mlp_layer_sequencer;
    import mlp_layer_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mlp_layer_sequencer_if #(.ACC_W(DEF_ACC_W)) if1 ();
    mlp_layer_sequencer_if #(.ACC_W(DEF_ACC_W)) if3 ();

    logic signed [DEF_ACC_W-1:0] tbl [16];
    assign if1.acc_in = tbl[if1.bias_addr];
    assign if3.acc_in = tbl[if3.bias_addr];

    mlp_layer_sequencer #(.MEM_LAT(1)) dut1 (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (if1)
    );

    mlp_layer_sequencer #(.MEM_LAT(3)) dut3 (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (if3)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference monitor for the MEM_LAT=1 build.
    bit chk_clr = 1'b0;
    int beats, clears, ens, ovl, clr_err, en_err, addr_err;
    int exp_p, exp_n;
    bit prev_beat, prev_first;

    always @(negedge clk) begin
        if (chk_clr || !reset_n) begin
            beats <= 0; clears <= 0; ens <= 0; ovl <= 0;
            clr_err <= 0; en_err <= 0; addr_err <= 0;
            exp_p <= 0; exp_n <= 0;
            prev_beat <= 1'b0; prev_first <= 1'b0;
        end else begin
            if (if1.mac_clear && if1.mac_en) ovl <= ovl + 1;
            if (if1.mac_clear !== prev_first) clr_err <= clr_err + 1;
            if (if1.mac_en !== (prev_beat && !prev_first))
                en_err <= en_err + 1;
            if (if1.mac_clear === 1'b1) clears <= clears + 1;
            if (if1.mac_en === 1'b1) ens <= ens + 1;
            if (if1.rd_en === 1'b1) begin
                beats <= beats + 1;
                if (int'(if1.pix_addr) != exp_p ||
                    int'(if1.wgt_addr) != exp_p * DEF_N_OUT + exp_n ||
                    int'(if1.bias_addr) != exp_n)
                    addr_err <= addr_err + 1;
                if (exp_p == DEF_N_PIX - 1) begin
                    exp_p <= 0;
                    exp_n <= (exp_n == DEF_N_OUT - 1) ? 0 : exp_n + 1;
                end else begin
                    exp_p <= exp_p + 1;
                end
            end
            prev_beat  <= (if1.rd_en === 1'b1);
            prev_first <= (if1.rd_en === 1'b1) && (if1.pix_addr == '0);
        end
    end

    task automatic run_wait(input bit lat3, input int exp_edge,
                            input string tag);
        int   edges = 0;
        int   busy_edge = -1;
        logic seen = 1'b0;
        while (seen !== 1'b1 && edges < 9000) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy_edge < 0 && (lat3 ? if3.busy : if1.busy) === 1'b1)
                busy_edge = edges - 1;
            seen = lat3 ? if3.done : if1.done;
        end
        chk({tag, "_done_edge"}, edges - 1, exp_edge);
        chk({tag, "_busy_edge"}, busy_edge, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  if1.busy, 0);
        chk({tag, "_done"},  if1.done, 0);
        chk({tag, "_digit"}, if1.predicted_digit, 0);
        chk({tag, "_rd_en"}, if1.rd_en, 0);
        chk({tag, "_pix"},   if1.pix_addr, 0);
        chk({tag, "_wgt"},   if1.wgt_addr, 0);
        chk({tag, "_bias"},  if1.bias_addr, 0);
        chk({tag, "_clr"},   if1.mac_clear, 0);
        chk({tag, "_en"},    if1.mac_en, 0);
    endtask

    task automatic chk_monitor(input string tag);
        chk({tag, "_beats"},  beats, 7840);
        chk({tag, "_clears"}, clears, 10);
        chk({tag, "_ens"},    ens, 7830);
        chk({tag, "_ovl"},    ovl, 0);
        chk({tag, "_clr_t"},  clr_err, 0);
        chk({tag, "_en_t"},   en_err, 0);
        chk({tag, "_addr"},   addr_err, 0);
    endtask

    task automatic drop_start();
        @(negedge clk);
        if1.start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        if1.start = 1'b0;
        if3.start = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        #1 reset_n = 1'b1;

        // ascending scores: last neuron wins
        for (int k = 0; k < 10; k++) tbl[k] = k * 100;
        @(negedge clk);
        #1 if1.start = 1'b1;
        run_wait(1'b0, 7871, "t1");
        chk("t1_digit", if1.predicted_digit, 9);
        chk("t1_busy", if1.busy, 0);
        @(negedge clk);
        chk_monitor("t1");

        // start held in DONE: no retrigger
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!(if1.done === 1'b1 && if1.busy === 1'b0 &&
                  if1.rd_en === 1'b0)) bad++;
        end
        chk("t5_hold_bad", bad, 0);
        chk("t5_no_rerun", beats, 7840);
        if1.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_done_low", if1.done, 0);
        chk("t5_digit_kept", if1.predicted_digit, 9);

        // tie between neurons 3 and 7
        tbl[0] = -5;   tbl[1] = 100; tbl[2] = 499; tbl[3] = 500;
        tbl[4] = -1000; tbl[5] = 0;  tbl[6] = 42;  tbl[7] = 500;
        tbl[8] = 499;  tbl[9] = 300;
        @(negedge clk);
        if1.start = 1'b1;
        run_wait(1'b0, 7871, "t2");
        chk("t2_digit", if1.predicted_digit, 3);
        drop_start();
        chk("t2_idle_done", if1.done, 0);

        // all scores at the minimum: digit keeps previous value
        for (int k = 0; k < 10; k++) tbl[k] = ACC_MIN;
        @(negedge clk);
        if1.start = 1'b1;
        run_wait(1'b0, 7871, "tmin");
        chk("tmin_digit", if1.predicted_digit, 3);
        drop_start();

        // reset mid-run, then a fresh run
        for (int k = 0; k < 10; k++) tbl[k] = k * 7;
        tbl[6] = 999;
        @(negedge clk);
        if1.start = 1'b1;
        repeat (3000) @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 chk_zero("t4_abort");
        repeat (2) @(negedge clk);
        chk_zero("t4_hold");
        #1 reset_n = 1'b1;
        run_wait(1'b0, 7871, "t4");
        chk("t4_digit", if1.predicted_digit, 6);
        @(negedge clk);
        chk_monitor("t4");
        drop_start();

        // MEM_LAT=3 build
        for (int k = 0; k < 10; k++) tbl[k] = k * 100;
        @(negedge clk);
        if3.start = 1'b1;
        run_wait(1'b1, 7891, "t6");
        chk("t6_digit", if3.predicted_digit, 9);
        chk("t6_other_idle", if1.busy, 0);
        if3.start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
